// File: rtl/fp_32_to_16_convert_pipe_if.sv
// Operand/result channel of the fp32 -> fp16 narrowing converter.
// The slave modport is the converter; the master modport drives operands and consumes results.
interface fp_32_to_16_convert_pipe_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] operand_fp32_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] result_o;
  logic [3:0]  flags_o;

  modport slave (
    input  in_valid_i,
    input  operand_fp32_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output result_o,
    output flags_o
  );

  modport master (
    output in_valid_i,
    output operand_fp32_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  result_o,
    input  flags_o
  );
endinterface

// File: rtl/fp_32_to_16_convert_pipe.sv
// Two-stage binary32 -> binary16 converter with round-to-nearest-even and sticky flags.
// S1 classifies and aligns the operand; S2 rounds and forms the result and per-result flags.
module fp_32_to_16_convert_pipe (
  input  logic                             clk_i,
  input  logic                             rst_i,
  fp_32_to_16_convert_pipe_if.slave        conv_if,
  input  logic                             clear_flags_i,
  output logic [3:0]                       sticky_flags_o
);

  localparam logic [2:0] CLS_NORM = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_ZERO = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_OVF  = 3'd4;
  localparam logic [2:0] CLS_NAN  = 3'd5;

  // Handshake: a beat moves when valid and ready are high in the same cycle; valid never
  // depends on ready, and ready depends only on downstream ready and stage occupancy.
  logic s2_load;
  logic in_ready;
  logic in_fire;
  logic out_fire;

  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_cls_q;
  logic        s1_sign_q;
  logic [4:0]  s1_exp_q;
  logic [9:0]  s1_kept_q;
  logic        s1_g_q;
  logic        s1_st_q;
  logic        s1_snan_q;

  logic        out_valid_q, out_valid_d;
  logic [15:0] result_q;
  logic [3:0]  flags_q;
  logic [3:0]  sticky_q, sticky_d;

  assign s2_load  = !out_valid_q || conv_if.out_ready_i;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = conv_if.in_valid_i && in_ready;
  assign out_fire = out_valid_q && conv_if.out_ready_i;

  // ---------------- S1: classification and alignment ----------------
  logic        op_sign;
  logic [7:0]  op_exp;
  logic [22:0] op_man;
  logic [23:0] sig;
  logic [7:0]  sh_raw;
  logic [4:0]  sh_sat;
  logic [35:0] sub_shift;
  logic [2:0]  cls_d;
  logic [4:0]  exp_d;
  logic [9:0]  kept_d;
  logic        g_d;
  logic        st_d;
  logic        snan_d;

  assign op_sign = conv_if.operand_fp32_i[31];
  assign op_exp  = conv_if.operand_fp32_i[30:23];
  assign op_man  = conv_if.operand_fp32_i[22:0];

  always_comb begin
    sig    = {1'b1, op_man};
    sh_raw = 8'd126 - op_exp;
    // Beyond 26 every significand bit is already below guard, so larger shifts are equivalent.
    sh_sat    = (sh_raw > 8'd26) ? 5'd26 : sh_raw[4:0];
    sub_shift = 36'({sig, 26'd0} >> sh_sat);

    cls_d  = CLS_NORM;
    exp_d  = 5'(op_exp - 8'd112);
    kept_d = op_man[22:13];
    g_d    = op_man[12];
    st_d   = |op_man[11:0];
    snan_d = 1'b0;

    if (op_exp == 8'hFF) begin
      cls_d  = (op_man != 23'd0) ? CLS_NAN : CLS_INF;
      snan_d = ~op_man[22];
    end else if (op_exp == 8'd0) begin
      cls_d = CLS_ZERO;
      g_d   = 1'b0;
      st_d  = |op_man;
    end else if (op_exp > 8'd142) begin
      cls_d = CLS_OVF;
    end else if (op_exp < 8'd113) begin
      cls_d  = CLS_SUB;
      exp_d  = 5'd0;
      kept_d = sub_shift[35:26];
      g_d    = sub_shift[25];
      st_d   = |sub_shift[24:0];
    end
  end

  assign s1_valid_d = in_ready ? conv_if.in_valid_i : s1_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= CLS_ZERO;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= 5'd0;
      s1_kept_q  <= 10'd0;
      s1_g_q     <= 1'b0;
      s1_st_q    <= 1'b0;
      s1_snan_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_cls_q  <= cls_d;
        s1_sign_q <= op_sign;
        s1_exp_q  <= exp_d;
        s1_kept_q <= kept_d;
        s1_g_q    <= g_d;
        s1_st_q   <= st_d;
        s1_snan_q <= snan_d;
      end
    end
  end

  // ---------------- S2: rounding and flag generation ----------------
  logic        round_up;
  logic        inexact;
  logic [14:0] rounded;
  logic [15:0] result_d;
  logic [3:0]  flags_d;

  always_comb begin
    round_up = s1_g_q & (s1_st_q | s1_kept_q[0]);
    inexact  = s1_g_q | s1_st_q;
    // A mantissa carry ripples into the exponent: subnormal -> 0x0400, 30 -> infinity.
    rounded  = {s1_exp_q, s1_kept_q} + {14'd0, round_up};
    result_d = {s1_sign_q, rounded};
    flags_d  = {3'b000, inexact};
    case (s1_cls_q)
      CLS_NAN: begin
        result_d = {s1_sign_q, 5'h1F, 10'h200};
        flags_d  = {s1_snan_q, 3'b000};
      end
      CLS_INF: begin
        result_d = {s1_sign_q, 15'h7C00};
        flags_d  = 4'b0000;
      end
      CLS_ZERO: begin
        result_d = {s1_sign_q, 15'h0000};
        flags_d  = {2'b00, s1_st_q, s1_st_q};
      end
      CLS_OVF: begin
        result_d = {s1_sign_q, 15'h7C00};
        flags_d  = 4'b0101;
      end
      CLS_SUB: begin
        flags_d = {2'b00, inexact & (rounded[14:10] == 5'd0), inexact};
      end
      default: begin
        if (rounded[14:10] == 5'h1F) flags_d = 4'b0101;
      end
    endcase
  end

  assign out_valid_d = s2_load ? s1_valid_q : out_valid_q;
  assign sticky_d    = clear_flags_i ? 4'h0 : (out_fire ? (sticky_q | flags_q) : sticky_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      result_q    <= 16'h0000;
      flags_q     <= 4'h0;
      sticky_q    <= 4'h0;
    end else begin
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      if (s2_load && s1_valid_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign conv_if.in_ready_o  = in_ready;
  assign conv_if.out_valid_o = out_valid_q;
  assign conv_if.result_o    = result_q;
  assign conv_if.flags_o     = flags_q;
  assign sticky_flags_o      = sticky_q;

endmodule

// File: tb/tb_fp_32_to_16_convert_pipe.sv
// Bench for the fp32 -> fp16 converter: value-level rounding model, in-order scoreboard,
// directed corner values, exhaustive fp16 round trip, backpressure, sticky and reset scenarios.
module tb_fp_32_to_16_convert_pipe;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_flags = 1'b0;
  logic [3:0] sticky;

  always #5 clk = ~clk;

  fp_32_to_16_convert_pipe_if bus ();

  fp_32_to_16_convert_pipe dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .conv_if        (bus),
    .clear_flags_i  (clear_flags),
    .sticky_flags_o (sticky)
  );

  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];
  logic [3:0]  sticky_m = 4'h0;
  int          xfer_cnt = 0;
  bit          rdy_rand = 1'b0;
  bit          hold_pending = 1'b0;
  logic [19:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Value-level rounding: quantise sig*2^(e-23) to the fp16 ulp 2^(max(e,-14)-10), RNE on the remainder.
  function automatic logic [19:0] model(input logic [31:0] x);
    logic   s;
    int     e32, e, ee, k, expf;
    longint sig, q, rem, half;
    bit     inexact;
    s   = x[31];
    e32 = int'(x[30:23]);
    if (e32 == 255) begin
      if (x[22:0] != 23'd0) return {(x[22] ? 4'h0 : 4'h8), s, 15'h7E00};
      return {4'h0, s, 15'h7C00};
    end
    if (e32 == 0) return {((x[22:0] != 23'd0) ? 4'h3 : 4'h0), s, 15'h0000};
    sig = longint'({1'b1, x[22:0]});
    e   = e32 - 127;
    ee  = (e < -14) ? -14 : e;
    k   = ee - e + 13;
    if (k >= 40) begin
      q = 0; rem = 1; half = 2;
    end else begin
      q    = sig >> k;
      rem  = sig - (q << k);
      half = longint'(1) << (k - 1);
    end
    if (rem > half || (rem == half && q[0])) q = q + 1;
    inexact = (rem != 0);
    if (q >= 2048) begin
      q  = q >> 1;
      ee = ee + 1;
    end
    expf = (q >= 1024) ? ee + 15 : 0;
    if (expf >= 31) return {4'h5, s, 15'h7C00};
    return {2'b00, (inexact && expf == 0), inexact, s, 5'(expf), 10'(q)};
  endfunction

  function automatic logic [31:0] widen(input logic [15:0] h);
    logic [4:0]  ex;
    logic [9:0]  mn;
    logic [22:0] f;
    int          p;
    ex = h[14:10];
    mn = h[9:0];
    if (ex == 5'd31) return {h[15], 8'hFF, mn, 13'h0};
    if (ex == 5'd0) begin
      if (mn == 10'd0) return {h[15], 31'h0};
      p = 0;
      for (int i = 0; i < 10; i++) if (mn[i]) p = i;
      f = 23'(mn) << (23 - p);
      return {h[15], 8'(p + 103), f};
    end
    return {h[15], 8'({3'b000, ex}) + 8'd112, mn, 13'h0};
  endfunction

  function automatic logic [19:0] canon(input logic [15:0] h);
    if (h[14:10] == 5'd31 && h[9:0] != 10'd0)
      return {(h[9] ? 4'h0 : 4'h8), h[15], 5'h1F, 10'h200};
    return {4'h0, h};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [22:0] m;
    logic        s;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return {s, 8'($urandom_range(98, 146)), m};
      2: begin
        case ($urandom_range(0, 2))
          0: m[12:0] = 13'h1000;
          1: m[12:0] = 13'h0000;
          default: m[12:0] = 13'h0FFF;
        endcase
        return {s, 8'($urandom_range(98, 146)), m};
      end
      default: begin
        case ($urandom_range(0, 3))
          0: m = 23'd0;
          1: m = 23'd1;
          2: m = 23'h400000;
          default: m = m;
        endcase
        return {s, ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, m};
      end
    endcase
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sticky_m     = 4'h0;
      hold_pending = 1'b0;
    end else begin
      check("sticky_flags", {28'd0, sticky}, {28'd0, sticky_m});
      if (hold_pending) begin
        check("hold_valid", {31'd0, bus.out_valid_o}, 32'd1);
        check("hold_data", {12'd0, bus.flags_o, bus.result_o}, {12'd0, held});
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h, expected no result", {bus.flags_o, bus.result_o});
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check("result_flags", {12'd0, bus.flags_o, bus.result_o}, {12'd0, e});
          sticky_m = clear_flags ? 4'h0 : (sticky_m | e[19:16]);
        end
      end else if (clear_flags) begin
        sticky_m = 4'h0;
      end
      hold_pending = bus.out_valid_o && !bus.out_ready_i;
      held         = {bus.flags_o, bus.result_o};
    end
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] op, input logic [19:0] e);
    int waited;
    bit acc;
    waited = 0;
    acc    = 1'b0;
    bus.in_valid_i     = 1'b1;
    bus.operand_fp32_i = op;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        acc = 1'b1;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready low for %0d cycles, expected acceptance", waited);
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  logic [31:0] vec_op [17] = '{
    32'h3F800000, 32'h477FE000, 32'hC0000000, 32'h3F801000, 32'h3F803000, 32'h477FF000,
    32'h33800000, 32'h33000000, 32'h33000001, 32'h387FE000, 32'h7F800001, 32'hFFC00000,
    32'hFF800000, 32'h00000001, 32'h7F7FFFFF, 32'h3F802000, 32'h80000000};
  logic [19:0] vec_exp [17] = '{
    20'h0_3C00, 20'h0_7BFF, 20'h0_C000, 20'h1_3C00, 20'h1_3C02, 20'h5_7C00,
    20'h0_0001, 20'h3_0000, 20'h3_0001, 20'h1_0400, 20'h8_7E00, 20'h0_FE00,
    20'h0_FC00, 20'h3_0000, 20'h5_7C00, 20'h0_3C01, 20'h0_8000};
  logic [31:0] bp_ops [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF800000, 32'h3F801000};

  // ---------------- main sequence ----------------
  initial begin
    int idx, base, n;
    logic [31:0] op;
    bus.in_valid_i     = 1'b0;
    bus.operand_fp32_i = 32'd0;
    bus.out_ready_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("reset_result", {16'd0, bus.result_o}, 32'd0);
    check("reset_flags", {28'd0, bus.flags_o}, 32'd0);
    check("reset_sticky", {28'd0, sticky}, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    bus.out_ready_i = 1'b1;

    for (int i = 0; i < 17; i++) begin
      check("model_pin", {12'd0, model(vec_op[i])}, {12'd0, vec_exp[i]});
      send(vec_op[i], vec_exp[i]);
    end
    drain();

    for (int h = 0; h < 65536; h++) send(widen(16'(h)), canon(16'(h)));
    drain();

    // Backpressure: consumer stalled while five operands are offered back to back.
    bus.out_ready_i = 1'b0;
    idx = 0;
    bus.in_valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.operand_fp32_i = bp_ops[idx];
      @(negedge clk);
      if (bus.in_ready_o) begin
        exp_q.push_back(model(bp_ops[idx]));
        idx++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepted", idx, 32'd2);
    check("bp_in_ready_low", {31'd0, bus.in_ready_o}, 32'd0);
    base = xfer_cnt;
    bus.out_ready_i = 1'b1;
    for (int i = 2; i < 5; i++) send(bp_ops[i], model(bp_ops[i]));
    check("bp_rate_3", xfer_cnt - base, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_rate_5", xfer_cnt - base, 32'd5);
    drain();

    // Sticky accumulation and clear priority.
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    check("sticky_cleared", {28'd0, sticky}, 32'd0);
    send(32'h3F801000, 20'h1_3C00);
    send(32'h7F800001, 20'h8_7E00);
    drain();
    check("sticky_accum_9", {28'd0, sticky}, 32'h9);
    send(32'h33000000, 20'h3_0000);
    drain();
    check("sticky_accum_b", {28'd0, sticky}, 32'hB);
    bus.out_ready_i = 1'b0;
    send(32'h477FF000, 20'h5_7C00);
    n = 0;
    while (!bus.out_valid_o && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("coincide_valid", {31'd0, bus.out_valid_o}, 32'd1);
    bus.out_ready_i = 1'b1;
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    check("sticky_clear_wins", {28'd0, sticky}, 32'd0);
    check("coincide_transferred", exp_q.size(), 32'd0);

    // Reset with two results in flight.
    bus.out_ready_i = 1'b0;
    send(32'h3F800000, 20'h0_3C00);
    send(32'h40000000, 20'h0_4000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("midrst_result", {16'd0, bus.result_o}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    bus.out_ready_i = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_output", {31'd0, bus.out_valid_o}, 32'd0);
    end
    @(posedge clk); #1;

    // Randomised traffic with random consumer stalls and occasional clears.
    rdy_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      op = rand_op();
      clear_flags = ($urandom_range(0, 31) == 0);
      send(op, model(op));
      if ($urandom_range(0, 3) == 0) begin
        clear_flags = 1'b0;
        @(posedge clk); #1;
      end
    end
    clear_flags = 1'b0;
    rdy_rand = 1'b0;
    @(posedge clk); #2;
    bus.out_ready_i = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_32_to_16_convert_pipe.md
# fp_32_to_16_convert_pipe

Pipelined IEEE-754 binary32 to binary16 converter with round-to-nearest-even, valid/ready handshakes on both sides, and sticky exception flags. It narrows fp32 accumulator results back to fp16 storage format before write-back. It is the counterpart of the fp16→fp32 widening path, and an fp16 value widened to fp32 must convert back bit-exactly.

## Interface
Parameters: none; the formats are fixed at binary32 in and binary16 out.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  operand_fp32_i is valid
- in_ready_o  out  1  converter accepts an operand this cycle
- operand_fp32_i  in  32  binary32 operand
- out_valid_o  out  1  result_o and flags_o are valid
- out_ready_i  in  1  consumer accepts the result this cycle
- result_o  out  16  binary16 result
- flags_o  out  4  per-result flags {invalid, overflow, underflow, inexact}
- clear_flags_i  in  1  clears the sticky flags
- sticky_flags_o  out  4  OR of flags_o over all results handed off since the last clear or reset

## Operation
- Fields: sign s = op[31]; exp e32 = op[30:23]; mantissa m = op[22:0]. Unbiased exponent e = e32 − 127. The sign always passes through unchanged.
- NaN (e32 = 255, m ≠ 0):
  - Result is {s, 5'h1F, 10'h200}, a quiet NaN; the payload is dropped.
  - invalid is set only when m[22] = 0 (signaling NaN).
- Infinity (e32 = 255, m = 0): result {s, 15'h7C00}; no flags.
- Zero or fp32 subnormal (e32 = 0):
  - Result is signed zero {s, 15'h0}.
  - If m ≠ 0, inexact and underflow are set.
- Normal, −14 ≤ e ≤ 15:
  - Exponent e16 = e32 − 112 (5 bits). Kept bits = m[22:13].
  - Guard g = m[12]; sticky st = |m[11:0]; lsb = m[13].
  - Round up when g & (st | lsb).
  - A mantissa carry increments e16. If e16 reaches 31, the result is infinity {s, 15'h7C00} and overflow is set.
- e > 15: result is infinity {s, 15'h7C00}; overflow and inexact are set.
- e < −14 (subnormal output):
  - Significand sig = {1, m} (24 bits).
  - Shift right by sh = −e − 1, so sh ≥ 14. When sh > 25, the shift saturates and all bits go to sticky.
  - Result mantissa = sig >> sh (10 bits). Guard is the next bit below; sticky is the OR of all remaining bits below guard.
  - RNE is applied as for normals. A carry out of the mantissa yields exponent field 1, i.e. 0x0400, the smallest normal; this falls out naturally from the adder.
  - underflow is set iff the result is inexact.
- inexact is set whenever g | st, and on every overflow.

## Timing
- Two-stage pipeline:
  - S1 registers the classification, e16/shift amount, kept bits, g and st.
  - S2 registers the rounded result and flags.
- Latency: 2 cycles from an accepted input to out_valid_o, with no stall.
- Throughput: 1 per cycle while out_ready_i = 1.
- Handshake:
  - A transfer occurs when valid & ready are both high in the same cycle.
  - S2 loads when !out_valid_o | out_ready_i.
  - in_ready_o = !s1_valid | s2_load. It is combinational from out_ready_i; there is no combinational path from in_valid_i.
  - result_o and flags_o stay stable while out_valid_o = 1 and out_ready_i = 0.
  - Results leave strictly in input order; none are dropped or duplicated.
- Sticky flags:
  - sticky_flags_o ORs in flags_o on each output transfer.
  - clear_flags_i takes priority: if clear and a transfer coincide, the register ends at 0 in that cycle and the transferred flags are lost. The bench must treat this as the defined behaviour.
- Reset values, applied whenever rst_i is sampled high (including mid-stream):
  - out_valid_o = 0, result_o = 16'h0, flags_o = 4'h0, sticky_flags_o = 4'h0, S1 valid = 0.
  - In-flight operands are discarded.
  - in_ready_o = 1 from the first cycle after reset.

## Test plan
- Exact values:
  - 0x3F800000 → 0x3C00, flags 0.
  - 0x477FE000 → 0x7BFF, flags 0.
  - 0xC0000000 → 0xC000, flags 0.
  - Exhaustive check: widen every fp16 pattern, convert back, and require the original fp16 to be returned (NaNs canonicalised).
- RNE:
  - 0x3F801000 → 0x3C00, inexact.
  - 0x3F803000 → 0x3C02, inexact.
  - 0x477FF000 → 0x7C00, overflow + inexact.
- Subnormals:
  - 0x33800000 → 0x0001, exact.
  - 0x33000000 → 0x0000, underflow + inexact.
  - 0x33000001 → 0x0001, underflow + inexact.
  - 0x387FE000 → 0x0400, inexact (no underflow).
- Specials:
  - 0x7F800001 → 0x7E00, invalid.
  - 0xFFC00000 → 0xFE00, no flags.
  - 0xFF800000 → 0xFC00.
  - 0x00000001 → 0x0000, underflow + inexact.
- Backpressure:
  - Send 5 back-to-back operands with out_ready_i = 0 for 4 cycles.
  - in_ready_o drops after 2 acceptances.
  - After release, all 5 results arrive in order, then 1 per cycle.
- Sticky/reset:
  - Sticky flags accumulate across results.
  - clear_flags_i coinciding with a transfer leaves 0.
  - Asserting rst_i with 2 results in flight gives out_valid_o = 0 the next cycle, and neither result ever appears.
